// File: rtl/input_cond_pkg.sv
// Shared defaults and sizing helper for the board input conditioner.
package input_cond_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned N_BUTTONS_DEF           = 4;
  localparam int unsigned N_SWITCHES_DEF          = 10;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One pin: two-flop synchroniser, per-bit stability counter, and registered edge pulses.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] TERM = W'(DEBOUNCE_CYCLES - 1);

  logic         sync1_q, sync1_d;
  logic         sync2_q, sync2_d;
  logic         stable_q, stable_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;

  always_comb begin
    sync1_d  = pin_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    // Any return to the stable level restarts the count, so glitches never accumulate.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces board KEY/SW pins for the Nios PIO exports; adds press/release/change pulses and W1C sticky press flags.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned N_BUTTONS         = N_BUTTONS_DEF,
  parameter int unsigned N_SWITCHES        = N_SWITCHES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned BUTTON_ACTIVE_LOW = 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [N_BUTTONS-1:0]  button_pin,
  input  logic [N_SWITCHES-1:0] switch_pin,
  output logic [N_BUTTONS-1:0]  button_external_connection_export,
  output logic [N_SWITCHES-1:0] switch_external_connection_export,
  output logic [N_BUTTONS-1:0]  button_press,
  output logic [N_BUTTONS-1:0]  button_release,
  output logic [N_SWITCHES-1:0] switch_change,
  output logic [N_BUTTONS-1:0]  button_sticky,
  input  logic [N_BUTTONS-1:0]  button_sticky_clr
);

  localparam logic BTN_IDLE = (BUTTON_ACTIVE_LOW != 0);

  logic [N_BUTTONS-1:0]  btn_rise, btn_fall;
  logic [N_SWITCHES-1:0] sw_rise, sw_fall;
  logic [N_BUTTONS-1:0]  sticky_q, sticky_d;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : gen_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (BTN_IDLE)
    ) u_deb (
      .clk    (clk_clk),
      .rst    (reset_reset),
      .pin_i  (button_pin[i]),
      .level_o(button_external_connection_export[i]),
      .rise_o (btn_rise[i]),
      .fall_o (btn_fall[i])
    );
  end

  for (genvar i = 0; i < N_SWITCHES; i++) begin : gen_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_deb (
      .clk    (clk_clk),
      .rst    (reset_reset),
      .pin_i  (switch_pin[i]),
      .level_o(switch_external_connection_export[i]),
      .rise_o (sw_rise[i]),
      .fall_o (sw_fall[i])
    );
  end

  // Active-low buttons press on a falling debounced level, release on a rising one.
  assign button_press   = BTN_IDLE ? btn_fall : btn_rise;
  assign button_release = BTN_IDLE ? btn_rise : btn_fall;
  assign switch_change  = sw_rise | sw_fall;

  // Set has priority over the write-1-to-clear strobe.
  always_comb begin
    sticky_d = (sticky_q & ~button_sticky_clr) | button_press;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) sticky_q <= '0;
    else             sticky_q <= sticky_d;
  end

  assign button_sticky = sticky_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce window.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button_pin = 4'hF;
  logic [9:0] switch_pin = '0;
  logic [3:0] btn_exp, press, release_p, sticky;
  logic [3:0] sticky_clr = '0;
  logic [9:0] sw_exp, change;

  int n_assert = 0;
  int n_fail   = 0;

  input_conditioner #(
    .N_BUTTONS        (4),
    .N_SWITCHES       (10),
    .DEBOUNCE_CYCLES  (4),
    .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .clk_clk                          (clk),
    .reset_reset                      (rst),
    .button_pin                       (button_pin),
    .switch_pin                       (switch_pin),
    .button_external_connection_export(btn_exp),
    .switch_external_connection_export(sw_exp),
    .button_press                     (press),
    .button_release                   (release_p),
    .switch_change                    (change),
    .button_sticky                    (sticky),
    .button_sticky_clr                (sticky_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_assert++;
      if (press !== 4'h0 || release_p !== 4'h0 || change !== 10'h000) begin
        n_fail++;
        $display("FAIL reset_pulses cyc=%0d press=%h release=%h change=%h required 0", c, press, release_p, change);
      end
    end
    n_assert++;
    if (btn_exp !== 4'hF) begin n_fail++; $display("FAIL reset_btn_exp got %h required f", btn_exp); end
    n_assert++;
    if (sw_exp !== 10'h000) begin n_fail++; $display("FAIL reset_sw_exp got %h required 000", sw_exp); end
    n_assert++;
    if (sticky !== 4'h0) begin n_fail++; $display("FAIL reset_sticky got %h required 0", sticky); end
  endtask

  task automatic test_press();
    button_pin[0] = 1'b0;
    tick(5);
    n_assert++;
    if (btn_exp !== 4'hF || press !== 4'h0) begin
      n_fail++; $display("FAIL press_early exp=%h press=%h required f/0", btn_exp, press);
    end
    tick();
    n_assert++;
    if (btn_exp !== 4'hE || press !== 4'h1) begin
      n_fail++; $display("FAIL press_edge exp=%h press=%h required e/1", btn_exp, press);
    end
    tick();
    n_assert++;
    if (press !== 4'h0 || sticky !== 4'h1) begin
      n_fail++; $display("FAIL press_after press=%h sticky=%h required 0/1", press, sticky);
    end
    button_pin[0] = 1'b1;
    tick(6);
    n_assert++;
    if (btn_exp !== 4'hF || release_p !== 4'h1 || press !== 4'h0) begin
      n_fail++; $display("FAIL release_edge exp=%h release=%h press=%h required f/1/0", btn_exp, release_p, press);
    end
    tick();
    n_assert++;
    if (release_p !== 4'h0 || sticky !== 4'h1) begin
      n_fail++; $display("FAIL release_after release=%h sticky=%h required 0/1", release_p, sticky);
    end
  endtask

  task automatic test_bounce();
    button_pin[1] = 1'b0;
    tick(3);
    button_pin[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_assert++;
      if (btn_exp !== 4'hF || press !== 4'h0) begin
        n_fail++; $display("FAIL bounce cyc=%0d exp=%h press=%h required f/0", c, btn_exp, press);
      end
    end
    // A full clean press must still need the whole window, proving the count restarted.
    button_pin[1] = 1'b0;
    tick(5);
    n_assert++;
    if (btn_exp !== 4'hF || press !== 4'h0) begin
      n_fail++; $display("FAIL bounce_restart_early exp=%h press=%h required f/0", btn_exp, press);
    end
    tick();
    n_assert++;
    if (btn_exp !== 4'hD || press !== 4'h2) begin
      n_fail++; $display("FAIL bounce_restart_edge exp=%h press=%h required d/2", btn_exp, press);
    end
    button_pin[1] = 1'b1;
    tick(8);
  endtask

  task automatic test_switch();
    switch_pin = 10'h201;
    tick(5);
    n_assert++;
    if (sw_exp !== 10'h000 || change !== 10'h000) begin
      n_fail++; $display("FAIL sw_rise_early exp=%h change=%h required 000/000", sw_exp, change);
    end
    tick();
    n_assert++;
    if (sw_exp !== 10'h201 || change !== 10'h201) begin
      n_fail++; $display("FAIL sw_rise_edge exp=%h change=%h required 201/201", sw_exp, change);
    end
    tick();
    n_assert++;
    if (change !== 10'h000) begin n_fail++; $display("FAIL sw_rise_once change=%h required 000", change); end
    tick(3);
    switch_pin = 10'h000;
    tick(5);
    n_assert++;
    if (sw_exp !== 10'h201 || change !== 10'h000) begin
      n_fail++; $display("FAIL sw_fall_early exp=%h change=%h required 201/000", sw_exp, change);
    end
    tick();
    n_assert++;
    if (sw_exp !== 10'h000 || change !== 10'h201) begin
      n_fail++; $display("FAIL sw_fall_edge exp=%h change=%h required 000/201", sw_exp, change);
    end
    tick();
    n_assert++;
    if (change !== 10'h000) begin n_fail++; $display("FAIL sw_fall_once change=%h required 000", change); end
  endtask

  task automatic test_sticky();
    button_pin[2] = 1'b0;
    tick(6);
    n_assert++;
    if (press !== 4'h4) begin n_fail++; $display("FAIL sticky_press1 press=%h required 4", press); end
    tick();
    n_assert++;
    if (sticky !== 4'h7) begin n_fail++; $display("FAIL sticky_set got %h required 7", sticky); end
    button_pin[2] = 1'b1;
    tick(8);
    button_pin[2] = 1'b0;
    tick(6);
    n_assert++;
    if (press !== 4'h4) begin n_fail++; $display("FAIL sticky_press2 press=%h required 4", press); end
    sticky_clr = 4'h4;
    tick();
    n_assert++;
    if (sticky !== 4'h7) begin n_fail++; $display("FAIL sticky_set_wins got %h required 7", sticky); end
    tick();
    n_assert++;
    if (sticky !== 4'h3) begin n_fail++; $display("FAIL sticky_clear got %h required 3", sticky); end
    sticky_clr = 4'h0;
    button_pin[2] = 1'b1;
    tick(8);
  endtask

  task automatic test_reset_mid_count();
    switch_pin = 10'h004;
    tick(4);
    rst = 1'b1;
    tick();
    n_assert++;
    if (sw_exp !== 10'h000 || change !== 10'h000 || sticky !== 4'h0) begin
      n_fail++; $display("FAIL midreset exp=%h change=%h sticky=%h required 000/000/0", sw_exp, change, sticky);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_assert++;
      if (sw_exp !== 10'h000 || change !== 10'h000) begin
        n_fail++; $display("FAIL midreset_wait cyc=%0d exp=%h change=%h required 000/000", c, sw_exp, change);
      end
    end
    tick();
    n_assert++;
    if (sw_exp !== 10'h004 || change !== 10'h004) begin
      n_fail++; $display("FAIL midreset_resync exp=%h change=%h required 004/004", sw_exp, change);
    end
    tick();
    n_assert++;
    if (change !== 10'h000) begin n_fail++; $display("FAIL midreset_once change=%h required 000", change); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_switch();
    test_sticky();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
